prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock, rising-edge.
REQ-005 The block SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-006 The block SHALL have port imem_req_valid  output  1  meaning fetch request valid.
REQ-007 The block SHALL have port imem_req_ready  input  1  meaning memory accepts the request.
REQ-008 The block SHALL have port imem_req_addr  output  XLEN  meaning word-aligned fetch address.
REQ-009 The block SHALL have port imem_resp_valid  input  1  meaning response data valid; responses arrive in request order.
REQ-010 The block SHALL have port imem_resp_data  input  32  meaning fetched instruction word.
REQ-011 The block SHALL have port redirect_valid  input  1  meaning flush and restart fetch.
REQ-012 The block SHALL have port redirect_pc  input  XLEN  meaning new fetch address.
REQ-013 The block SHALL have port inst_valid  output  1  meaning queue head is valid.
REQ-014 The block SHALL have port inst_ready  input  1  meaning consumer takes the head.
REQ-015 The block SHALL have port inst_pc  output  XLEN  meaning PC of the head instruction.
REQ-016 The block SHALL have port inst_data  output  32  meaning head instruction word.
REQ-017 The block SHALL have port queue_count  output  $clog2(DEPTH)+1  meaning occupied entries.

Function
REQ-018 A request SHALL be issued only when queue_count + outstanding < DEPTH, so accepted responses never overflow; outstanding counts accepted, unanswered requests (max DEPTH).
REQ-019 A request SHALL transfer on imem_req_valid && imem_req_ready; fetch_pc then advances by 4, wrapping modulo 2^XLEN.
REQ-020 imem_req_valid SHALL stay asserted with stable imem_req_addr until accepted, unless a redirect occurs.
REQ-021 A non-discarded response SHALL be written to the queue tail with its PC; it SHALL be visible on inst_* the next cycle (1-cycle latency, no bypass).
REQ-022 The head SHALL pop on inst_valid && inst_ready; simultaneous push and pop SHALL leave queue_count unchanged.
REQ-023 inst_valid SHALL equal (queue_count != 0); inst_pc/inst_data SHALL be held stable while inst_valid && !inst_ready.
REQ-024 On redirect_valid, the next cycle SHALL have: queue empty, fetch_pc = {redirect_pc[XLEN-1:2],2'b00}, discard = outstanding minus any response received that cycle.
REQ-025 imem_req_valid SHALL be low in any cycle with redirect_valid high; redirect overrides push and pop in the same cycle.
REQ-026 While discard > 0, each response SHALL decrement discard and outstanding and SHALL NOT be enqueued; new requests are permitted during discard.
REQ-027 Back-to-back redirects SHALL each restart fetch; only the last redirect_pc takes effect.
REQ-028 Queue pointers SHALL wrap modulo DEPTH; full (count==DEPTH) and empty (count==0) SHALL be distinguished by queue_count.

Reset
REQ-029 While reset is low: imem_req_valid=0, inst_valid=0, queue_count=0, outstanding=0, discard=0, fetch_pc=RESET_PC, pointers=0; queue payload not reset.
REQ-030 In the first cycle after reset deasserts, imem_req_valid SHALL be 1 with imem_req_addr=RESET_PC.
REQ-031 Reset asserted mid-operation SHALL abandon in-flight requests; memory is reset alongside.

Structure
REQ-032 Instruction width (32) and PC increment (4) SHALL be constants in the shared core package.
REQ-033 The queue SHALL be a sub-module sync_fifo (parametrised WIDTH, DEPTH) storing {pc, instruction}.

Verification
REQ-034 Reset release, ready=1, 1-cycle memory, inst_ready=1 -> addresses 0,4,8,...; inst_pc 0 appears 2 cycles after first request.
REQ-035 inst_ready=0, DEPTH=4 -> exactly 4 requests issued, queue_count=4, imem_req_valid=0 until a pop.
REQ-036 Redirect to 0x103 with 2 outstanding -> both responses dropped, next request addr 0x100, first inst_pc 0x100.
REQ-037 imem_req_ready=0 for 5 cycles -> imem_req_addr held at 0x8 throughout, fetch resumes at 0x8.
REQ-038 fetch_pc=0xFFFFFFFC, XLEN=32 -> next request addr 0x00000000.
REQ-039 Reset low while queue holds 3 entries -> inst_valid=0, queue_count=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/prefetch_unit_pkg.sv
// Shared core constants for the instruction prefetch path.
package prefetch_unit_pkg;

    localparam int unsigned ILEN    = 32;
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with single-cycle flush; the occupancy count tells full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: credit-limited in-order fetch into a small queue,
// with redirect flush and discard of responses still in flight.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [ILEN-1:0]        imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [XLEN-1:0]        inst_pc,
    output logic [ILEN-1:0]        inst_data,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned FW = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [XLEN-1:0] redirect_aligned;
    logic            credit_ok;
    logic            accept;
    logic            drop;
    logic            push;
    logic            pop;
    logic [FW-1:0]   head;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Every accepted request reserves a queue slot until its response lands or is dropped.
    assign credit_ok      = (SW'(queue_count) + SW'(outst_q)) < SW'(DEPTH);
    assign imem_req_valid = reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;

    assign accept = imem_req_valid && imem_req_ready;
    assign drop   = imem_resp_valid && (discard_q != '0);
    assign push   = imem_resp_valid && !drop && !redirect_valid;
    assign pop    = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            outst_d    = outst_q - CW'(imem_resp_valid);
            discard_d  = outst_q - CW'(imem_resp_valid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
            end
            if (drop) begin
                discard_d = discard_q - CW'(1);
            end
            outst_d = outst_q + CW'(accept) - CW'(imem_resp_valid);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({resp_pc_q, imem_resp_data}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .count_o     (queue_count)
    );

    assign inst_valid = (queue_count != '0);
    assign inst_pc    = head[ILEN +: XLEN];
    assign inst_data  = head[ILEN-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: a queue-based model of requests in flight and
// the instruction queue is checked every cycle, plus hand-computed scenario points.
module tb_prefetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic [2:0]  queue_count;

    prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
        .queue_count     (queue_count)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        inflight[$];
    ent_t        iq[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          lat;
    int          checks;
    int          failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs at negedge, compare against the model, then advance the model.
    task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] rp);
        req_t e;
        bit   resp;
        bit   exp_rv;
        @(negedge clk);
        reset          = 1'b1;
        imem_req_ready = rr;
        inst_ready     = ir;
        redirect_valid = rd;
        redirect_pc    = rp;
        resp = 1'b0;
        if (inflight.size() > 0) begin
            resp = (inflight[0].due <= cyc);
        end
        imem_resp_valid = resp;
        imem_resp_data  = 32'hDEAD_BEEF;
        if (resp) begin
            imem_resp_data = mem_word(inflight[0].addr);
        end
        #1;
        exp_rv = !rd && ((iq.size() + inflight.size()) < DEPTH);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("req_addr", 64'(imem_req_addr), 64'(m_fetch_pc));
        end
        chk("inst_valid", 64'(inst_valid), 64'(iq.size() != 0));
        chk("queue_count", 64'(queue_count), 64'(iq.size()));
        if (iq.size() != 0) begin
            chk("inst_pc", 64'(inst_pc), 64'(iq[0].pc));
            chk("inst_data", 64'(inst_data), 64'(iq[0].data));
        end
        if (resp) begin
            e = inflight.pop_front();
        end
        if (rd) begin
            iq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fetch_pc = rp & 32'hFFFF_FFFC;
        end else begin
            if (ir && iq.size() != 0) begin
                void'(iq.pop_front());
            end
            if (resp && !e.stale) begin
                iq.push_back('{pc: e.addr, data: mem_word(e.addr)});
            end
            if (exp_rv && rr) begin
                inflight.push_back('{addr: m_fetch_pc, due: cyc + lat, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    // Assert reset at a negedge and check the outputs clear at once; memory forgets in-flight work.
    task automatic do_reset(input int n, input int exp_pre);
        @(negedge clk);
        if (exp_pre >= 0) begin
            chk("pre_reset_count", 64'(queue_count), 64'(exp_pre));
        end
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        inst_ready      = 1'b0;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'(1'b0));
        chk("rst_inst_valid", 64'(inst_valid), 64'(1'b0));
        chk("rst_count", 64'(queue_count), 64'(3'd0));
        iq.delete();
        inflight.delete();
        m_fetch_pc = RESET_PC;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        bit found;
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        lat             = 1;
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;
        m_fetch_pc      = RESET_PC;
        do_reset(2, -1);

        // Streaming with a 1-cycle memory: addresses 0,4,8,... and pc 0 two cycles after first request.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            chk("stream_addr", 64'(imem_req_addr), 64'(32'(4 * i)));
            if (i == 0) chk("first_req_valid", 64'(imem_req_valid), 64'(1'b1));
            if (i == 1) chk("no_bypass", 64'(inst_valid), 64'(1'b0));
            if (i >= 2) chk("stream_pc", 64'(inst_pc), 64'(32'(4 * (i - 2))));
        end

        // Consumer stalled: exactly DEPTH requests, then fetch stops until a pop.
        do_reset(2, -1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (imem_req_valid) n++;
        end
        chk("full_req_total", 64'(n), 64'(4));
        chk("full_count", 64'(queue_count), 64'(3'd4));
        chk("full_req_low", 64'(imem_req_valid), 64'(1'b0));
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("refill_valid", 64'(imem_req_valid), 64'(1'b1));
        chk("refill_addr", 64'(imem_req_addr), 64'(32'h10));

        // Redirect with two requests outstanding on a 3-cycle memory.
        do_reset(2, -1);
        lat = 3;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h103);
        chk("redir_req_low", 64'(imem_req_valid), 64'(1'b0));
        step(1'b1, 1'b1, 1'b0, '0);
        chk("redir_addr", 64'(imem_req_addr), 64'(32'h100));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (inst_valid) begin
                found = 1'b1;
                chk("redir_first_pc", 64'(inst_pc), 64'(32'h100));
            end
        end
        chk("redir_found", 64'(found), 64'(1'b1));

        // Memory not ready for 5 cycles: address held at 0x8.
        lat = 1;
        do_reset(2, -1);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            chk("stall_addr", 64'(imem_req_addr), 64'(32'h8));
            chk("stall_valid", 64'(imem_req_valid), 64'(1'b1));
        end
        step(1'b1, 1'b1, 1'b0, '0);
        chk("resume_addr", 64'(imem_req_addr), 64'(32'h8));
        step(1'b1, 1'b1, 1'b0, '0);
        chk("resume_next", 64'(imem_req_addr), 64'(32'hC));

        // Back-to-back redirects, then address wrap at the top of the space.
        step(1'b1, 1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b1, 1'b1, 32'h305);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("b2b_addr", 64'(imem_req_addr), 64'(32'h304));
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_top", 64'(imem_req_addr), 64'(32'hFFFF_FFFC));
        step(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_zero", 64'(imem_req_addr), 64'(32'h0));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Reset while three entries are queued, then restart at RESET_PC.
        do_reset(2, -1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
        do_reset(2, 3);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("restart_valid", 64'(imem_req_valid), 64'(1'b1));
        chk("restart_addr", 64'(imem_req_addr), 64'(RESET_PC));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
